aes128_decryptor: RTL and testbench

AES128_DECRYPTOR -- requirements
Module: aes128_decryptor

---
 rtl/aes128_decryptor.sv | 216 +++++++++++++++++++++
 tb/tb_aes128_decryptor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_decryptor.sv
// Iterative AES-128 decryptor: forward key expansion to round key 10, then
// one inverse round per cycle with the key schedule unwound on the fly.
module aes128_decryptor #(
   parameter int unsigned WIDTH = 128
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start,
   input  logic [WIDTH-1:0] ciphertext_i,
   input  logic [WIDTH-1:0] key_i,
   output logic [WIDTH-1:0] plaintext_o,
   output logic             data_ready_o,
   output logic             busy_o,
   output logic             valid_o
);

   typedef enum logic [2:0] {IDLE, KEYEXP, ADDK, ROUND, FINAL, DONE} fsm_t;

   fsm_t             fsm_q, fsm_d;
   logic [WIDTH-1:0] blk_q;
   logic [WIDTH-1:0] key_q;
   logic [3:0]       cnt_q;
   logic [3:0]       rc_idx;
   logic [127:0]     key_next, key_prev, last_out, round_out;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[3'(i)]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (inverse of 0 maps to 0, as the S-box needs)
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = gf_mul(x, x);
      acc = sq;
      for (int unsigned i = 0; i < 6; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Undo one schedule step: recover words 3..1 by XOR, then word 0 needs old word 3
   function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[31:0] ^ k[63:32];
      w2 = k[63:32] ^ k[95:64];
      w1 = k[95:64] ^ k[127:96];
      w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            o[7'(127 - 8*(4*c + r)) -: 8] = s[7'(127 - 8*(4*((c + 4 - r) % 4) + r)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int unsigned i = 0; i < 16; i++)
         o[7'(127 - 8*i) -: 8] = inv_sbox(s[7'(127 - 8*i) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = s[7'(127 - 32*c) -: 8];
         a1 = s[7'(119 - 32*c) -: 8];
         a2 = s[7'(111 - 32*c) -: 8];
         a3 = s[7'(103 - 32*c) -: 8];
         o[7'(127 - 32*c) -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[7'(119 - 32*c) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[7'(111 - 32*c) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[7'(103 - 32*c) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Shared round datapath; FINAL unwinds K1 -> K0 with the round-1 Rcon
   always_comb begin
      rc_idx    = (fsm_q == FINAL) ? '0 : cnt_q;
      key_next  = fwd_key(key_q, rcon(cnt_q));
      key_prev  = inv_key(key_q, rcon(rc_idx));
      last_out  = inv_sub_bytes(inv_shift_rows(blk_q)) ^ key_prev;
      round_out = inv_mix_columns(last_out);
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) fsm_q <= IDLE;
      else       fsm_q <= fsm_d;
   end

   // Next-state logic
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (start) fsm_d = KEYEXP;
         KEYEXP:  if (cnt_q == 4'd9) fsm_d = ADDK;
         ADDK:    fsm_d = ROUND;
         ROUND:   if (cnt_q == 4'd1) fsm_d = FINAL;
         FINAL:   fsm_d = DONE;
         DONE:    fsm_d = start ? KEYEXP : IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy_o       = 1'b0;
      data_ready_o = 1'b0;
      case (fsm_q)
         KEYEXP, ADDK, ROUND, FINAL: busy_o = 1'b1;
         DONE:                       data_ready_o = 1'b1;
         default: ;
      endcase
   end

   // Datapath: the block register doubles as the ciphertext latch until ADDK
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         blk_q       <= '0;
         key_q       <= '0;
         cnt_q       <= '0;
         plaintext_o <= '0;
         valid_o     <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE, DONE: begin
               if (start) begin
                  blk_q   <= ciphertext_i;
                  key_q   <= key_i;
                  cnt_q   <= '0;
                  valid_o <= 1'b0;
               end
            end
            KEYEXP: begin
               key_q <= key_next;
               if (cnt_q != 4'd9) cnt_q <= cnt_q + 4'd1;
            end
            ADDK: blk_q <= blk_q ^ key_q;
            ROUND: begin
               blk_q <= round_out;
               key_q <= key_prev;
               if (cnt_q != 4'd1) cnt_q <= cnt_q - 4'd1;
            end
            FINAL: begin
               plaintext_o <= last_out;
               key_q       <= key_prev;
               valid_o     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_decryptor.sv
// Directed bench for aes128_decryptor using FIPS-197 and SP800-38A vectors.
module tb_aes128_decryptor;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         start = 1'b0;
   logic [127:0] ciphertext_i = '0;
   logic [127:0] key_i = '0;
   logic [127:0] plaintext_o;
   logic         data_ready_o;
   logic         busy_o;
   logic         valid_o;

   int unsigned checks = 0;
   int unsigned errors = 0;

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

   aes128_decryptor #(.WIDTH(128)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start        (start),
      .ciphertext_i (ciphertext_i),
      .key_i        (key_i),
      .plaintext_o  (plaintext_o),
      .data_ready_o (data_ready_o),
      .busy_o       (busy_o),
      .valid_o      (valid_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   // Launch one decryption from IDLE, scramble inputs after acceptance, wait for the pulse
   task automatic run_op(input logic [127:0] k, input logic [127:0] c,
                         output logic [127:0] pt, output int unsigned lat);
      key_i = k;
      ciphertext_i = c;
      start = 1'b1;
      @(negedge clk_i);
      start = 1'b0;
      key_i = ~k;
      ciphertext_i = ~c;
      lat = 0;
      while (data_ready_o !== 1'b1 && lat < 40) begin
         @(negedge clk_i);
         lat++;
      end
      pt = plaintext_o;
      @(negedge clk_i);
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      start = 1'b1;
      key_i = KEY_B;
      ciphertext_i = CT_B;
      repeat (3) @(negedge clk_i);
      checks++; if (plaintext_o !== '0) begin errors++; $display("FAIL reset_plaintext got %h want %h", plaintext_o, 128'h0); end
      checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", data_ready_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
      checks++; if (dut.key_q !== '0) begin errors++; $display("FAIL reset_key got %h want %h", dut.key_q, 128'h0); end
   endtask

   // start already high: the first edge with rst_i low must accept it
   task automatic test_app_b;
      int unsigned n;
      bit busy_ok;
      rst_i = 1'b0;
      @(negedge clk_i);
      start = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      while (data_ready_o !== 1'b1 && n < 40) begin
         if (busy_o !== 1'b1) busy_ok = 1'b0;
         if (n == 10) begin
            checks++; if (dut.key_q !== RK10_B) begin errors++; $display("FAIL appb_round_key10 got %h want %h", dut.key_q, RK10_B); end
         end
         @(negedge clk_i);
         n++;
      end
      checks++; if (n !== 21) begin errors++; $display("FAIL appb_latency got %0d want 21", n); end
      checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL appb_busy_during got 0 want 1"); end
      checks++; if (plaintext_o !== PT_B) begin errors++; $display("FAIL appb_plaintext got %h want %h", plaintext_o, PT_B); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL appb_valid got %b want 1", valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL appb_busy_done got %b want 0", busy_o); end
      @(negedge clk_i);
      checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL appb_ready_pulse got %b want 0", data_ready_o); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL appb_valid_hold got %b want 1", valid_o); end
      checks++; if (plaintext_o !== PT_B) begin errors++; $display("FAIL appb_plaintext_hold got %h want %h", plaintext_o, PT_B); end
   endtask

   task automatic test_app_c;
      int unsigned n;
      key_i = KEY_C;
      ciphertext_i = CT_C;
      start = 1'b1;
      @(negedge clk_i);
      start = 1'b0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL appc_valid_clear got %b want 0", valid_o); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL appc_busy got %b want 1", busy_o); end
      n = 0;
      while (data_ready_o !== 1'b1 && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      checks++; if (n !== 21) begin errors++; $display("FAIL appc_latency got %0d want 21", n); end
      checks++; if (plaintext_o !== PT_C) begin errors++; $display("FAIL appc_plaintext got %h want %h", plaintext_o, PT_C); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL appc_valid got %b want 1", valid_o); end
      @(negedge clk_i);
   endtask

   // start pulses while busy and input changes after acceptance must not disturb the run
   task automatic test_ignore_start;
      int unsigned n;
      key_i = '0;
      ciphertext_i = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
      start = 1'b1;
      @(negedge clk_i);
      start = 1'b0;
      key_i = KEY_B;
      ciphertext_i = CT_B;
      n = 0;
      while (data_ready_o !== 1'b1 && n < 40) begin
         if (n == 5 || n == 20) start = 1'b1;
         else start = 1'b0;
         @(negedge clk_i);
         n++;
      end
      start = 1'b0;
      checks++; if (n !== 21) begin errors++; $display("FAIL ignore_latency got %0d want 21", n); end
      checks++; if (plaintext_o !== '0) begin errors++; $display("FAIL ignore_plaintext got %h want %h", plaintext_o, 128'h0); end
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ignore_no_relaunch got %b want 0", busy_o); end
      checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL ignore_ready_pulse got %b want 0", data_ready_o); end
   endtask

   task automatic test_vectors;
      logic [127:0] cts [4];
      logic [127:0] pts [4];
      logic [127:0] pt;
      int unsigned  lat;
      cts = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
              128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};
      pts = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
              128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
      for (int i = 0; i < 4; i++) begin
         run_op(KEY_B, cts[i], pt, lat);
         checks++; if (pt !== pts[i]) begin errors++; $display("FAIL vector%0d_plaintext got %h want %h", i, pt, pts[i]); end
         checks++; if (lat !== 21) begin errors++; $display("FAIL vector%0d_latency got %0d want 21", i, lat); end
      end
   endtask

   task automatic test_back_to_back;
      int unsigned pulses, first, second, n;
      bit prev, long_pulse, pt_ok;
      key_i = KEY_B;
      ciphertext_i = CT_B;
      start = 1'b1;
      pulses = 0; first = 999; second = 999;
      prev = 1'b0; long_pulse = 1'b0; pt_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (data_ready_o === 1'b1) begin
            pulses++;
            if (pulses == 1) first = i;
            else if (pulses == 2) second = i;
            if (plaintext_o !== PT_B) pt_ok = 1'b0;
         end
         if (prev && data_ready_o === 1'b1) long_pulse = 1'b1;
         prev = (data_ready_o === 1'b1);
      end
      start = 1'b0;
      checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
      checks++; if (first !== 21) begin errors++; $display("FAIL b2b_first got %0d want 21", first); end
      checks++; if (second !== 43) begin errors++; $display("FAIL b2b_second got %0d want 43", second); end
      checks++; if (long_pulse !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width got %b want 0", long_pulse); end
      checks++; if (pt_ok !== 1'b1) begin errors++; $display("FAIL b2b_plaintext got 0 want 1"); end
      n = 0;
      while (data_ready_o !== 1'b1 && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      checks++; if (data_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_third_done got %b want 1", data_ready_o); end
      @(negedge clk_i);
   endtask

   task automatic test_reset_abort;
      int unsigned spurious;
      logic [127:0] pt;
      int unsigned  lat;
      key_i = KEY_C;
      ciphertext_i = CT_C;
      start = 1'b1;
      @(negedge clk_i);
      start = 1'b0;
      repeat (11) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      checks++; if (plaintext_o !== '0) begin errors++; $display("FAIL abort_plaintext got %h want %h", plaintext_o, 128'h0); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", valid_o); end
      checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", data_ready_o); end
      checks++; if (dut.blk_q !== '0) begin errors++; $display("FAIL abort_state_reg got %h want %h", dut.blk_q, 128'h0); end
      checks++; if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL abort_counter got %0d want 0", dut.cnt_q); end
      spurious = 0;
      repeat (30) begin
         @(negedge clk_i);
         if (data_ready_o !== 1'b0 || busy_o !== 1'b0) spurious++;
      end
      checks++; if (spurious !== 0) begin errors++; $display("FAIL abort_quiet got %0d want 0", spurious); end
      run_op(KEY_B, CT_B, pt, lat);
      checks++; if (pt !== PT_B) begin errors++; $display("FAIL abort_rerun_plaintext got %h want %h", pt, PT_B); end
      checks++; if (lat !== 21) begin errors++; $display("FAIL abort_rerun_latency got %0d want 21", lat); end
   endtask

   initial begin
      test_reset;
      test_app_b;
      test_app_c;
      test_ignore_start;
      test_vectors;
      test_back_to_back;
      test_reset_abort;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
